// File: rtl/ms_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module : ms_pipe_pkg
// Brief  : Shared constants and count-width helper for the ms_pipe pipeline.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ms_pipe_pkg;

  localparam int c_default_data_width = 32;
  localparam int c_default_depth      = 1;

  // Room for DEPTH stage entries plus one optional skid entry.
  function automatic int count_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ms_pipe_stage.sv
//------------------------------------------------------------------------------
// Module : ms_pipe_stage
// Brief  : One pipeline register: data plus valid, with flush/load/clear/hold.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ms_pipe_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VAL  = '0
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Priority: flush, then load, then clear; otherwise the stage holds.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= FLUSH_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/ms_pipe.sv
//------------------------------------------------------------------------------
// Module : ms_pipe
// Brief  : Bubble-collapsing valid/ready pipeline of DEPTH stages with flush.
//          Optional skid entry in front of stage 0 via MS_PIPE_SKID_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ms_pipe
  import ms_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = c_default_data_width,
  parameter int                    DEPTH      = c_default_depth,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VAL  = '0
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  input  logic                          i_flush,
  output logic [count_width(DEPTH)-1:0] o_count
);

  localparam int c_cw = count_width(DEPTH);

  logic [DEPTH-1:0]      w_valid;
  logic [DATA_WIDTH-1:0] w_data [DEPTH];
  logic [DATA_WIDTH-1:0] w_in   [DEPTH];
  logic [DEPTH-1:0]      w_move;
  logic [DEPTH-1:0]      w_load;
  logic [DATA_WIDTH-1:0] w_s0_data;
  logic                  w_s0_load;
  logic                  w_s0_free;
  logic                  w_accept;
  logic                  w_emit;
  logic [c_cw-1:0]       r_count;

  // A stage moves when its successor is empty or itself moving; resolved from the output back.
  always_comb begin
    w_move          = '0;
    w_move[DEPTH-1] = w_valid[DEPTH-1] & i_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_move[i] = w_valid[i] & (~w_valid[i+1] | w_move[i+1]);
    end
  end

  always_comb begin
    w_load[0] = w_s0_load;
    w_in[0]   = w_s0_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_load[i] = w_move[i-1];
      w_in[i]   = w_data[i-1];
    end
  end

  assign w_s0_free = ~w_valid[0] | w_move[0];
  assign w_emit    = w_move[DEPTH-1];
  assign w_accept  = i_valid & o_ready;

`ifdef MS_PIPE_SKID_EN
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;

  assign o_ready   = ~r_skid_valid & ~i_flush;
  // An empty skid is bypassed so the accepted word lands directly in stage 0.
  assign w_s0_load = r_skid_valid ? w_s0_free : (w_accept & w_s0_free);
  assign w_s0_data = r_skid_valid ? r_skid_data : i_data;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (i_flush) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (r_skid_valid) begin
      if (w_s0_free) r_skid_valid <= 1'b0;
    end else if (w_accept && !w_s0_free) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end
`else
  assign o_ready   = ~i_flush & w_s0_free;
  assign w_s0_load = w_accept;
  assign w_s0_data = i_data;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    ms_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .FLUSH_VAL  (FLUSH_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_nrst  (i_nrst),
      .i_flush (i_flush),
      .i_load  (w_load[g]),
      .i_clear (w_move[g]),
      .i_data  (w_in[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (w_accept && !w_emit) begin
      r_count <= r_count + c_cw'(1);
    end else if (!w_accept && w_emit) begin
      r_count <= r_count - c_cw'(1);
    end
  end

  assign o_valid = w_valid[DEPTH-1];
  assign o_data  = w_data[DEPTH-1];
  assign o_count = r_count;

endmodule

`default_nettype wire
